// File: rtl/wb_imem_dmem_arbiter.sv
// Two-master (iwb/dwb) to one-slave Wishbone classic arbiter with a registered grant FSM.
// Optional grant watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_imem_dmem_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ROUND_ROBIN = 1,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  output logic                    s_we_o,
  output logic [DATA_WIDTH/8-1:0] s_sel_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  input  logic                    s_ack_i,
  input  logic                    s_err_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   last_d_q, last_d_d;
  logic   req0, req1;
  logic   gnt_i, gnt_d;
  logic   g_cyc, g_stb, g_ack, g_err;
  logic   timeout_hit;

  assign req0  = m0_cyc_i & m0_stb_i;
  assign req1  = m1_cyc_i & m1_stb_i;
  assign gnt_i = (state_q == GNT_I);
  assign gnt_d = (state_q == GNT_D);

  // Handshake of whichever master currently owns the slave
  assign g_cyc = (gnt_i & m0_cyc_i) | (gnt_d & m1_cyc_i);
  assign g_stb = (gnt_i & m0_stb_i) | (gnt_d & m1_stb_i);
  assign g_ack = g_cyc & g_stb & s_ack_i;
  assign g_err = g_cyc & g_stb & s_err_i;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Cleared while idle, so it always starts from zero on grant entry
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (!(s_ack_i || s_err_i)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // A genuine ack or err in the expiry cycle wins over the forced error
  assign timeout_hit = g_cyc && (cnt_q == CNT_W'(TIMEOUT_CYC)) && !s_ack_i && !s_err_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYC);
  assign timeout_hit    = 1'b0;
`endif

  // Grant sequencing; every grant returns through IDLE, giving one dead cycle
  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          if ((ROUND_ROBIN != 0) && last_d_q) begin
            state_d = GNT_I;
          end else begin
            state_d = GNT_D;
          end
        end else if (req0) begin
          state_d = GNT_I;
        end else if (req1) begin
          state_d = GNT_D;
        end
      end
      default: begin
        if (!g_cyc || g_ack || g_err || timeout_hit) begin
          state_d = IDLE;
        end
      end
    endcase
    if (state_q == IDLE && state_d == GNT_I) begin
      last_d_d = 1'b0;
    end else if (state_q == IDLE && state_d == GNT_D) begin
      last_d_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
    end
  end

  // Slave-side mux of the granted master
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    if (gnt_i) begin
      s_adr_o = m0_adr_i;
      s_sel_o = '1;
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i;
    end else if (gnt_d) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_we_o  = m1_we_i;
      s_sel_o = m1_sel_i;
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i;
    end
    if (timeout_hit) begin
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
    end
  end

  assign m0_dat_o = (gnt_i | gnt_d) ? s_dat_i : '0;
  assign m1_dat_o = (gnt_i | gnt_d) ? s_dat_i : '0;
  assign m0_ack_o = gnt_i & g_ack;
  assign m1_ack_o = gnt_d & g_ack;
  assign m0_err_o = gnt_i & (g_err | timeout_hit);
  assign m1_err_o = gnt_d & (g_err | timeout_hit);

endmodule

// File: tb/tb_wb_imem_dmem_arbiter.sv
// Directed bench for wb_imem_dmem_arbiter: a round-robin instance and a fixed-priority
// instance share all inputs; expected values are hand-derived per step.
module tb_wb_imem_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_adr_i, m1_adr_i, m1_dat_i, s_dat_i;
  logic        m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i, s_ack_i, s_err_i;
  logic [3:0]  m1_sel_i;

  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_we_o, s_cyc_o, s_stb_o;
  logic [3:0]  s_sel_o;

  logic [31:0] fp_m0_dat_o, fp_m1_dat_o, fp_s_adr_o, fp_s_dat_o;
  logic        fp_m0_ack_o, fp_m0_err_o, fp_m1_ack_o, fp_m1_err_o, fp_s_we_o, fp_s_cyc_o, fp_s_stb_o;
  logic [3:0]  fp_s_sel_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_imem_dmem_arbiter #(.ROUND_ROBIN(1)) dut (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i)
  );

  wb_imem_dmem_arbiter #(.ROUND_ROBIN(0)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
    .m0_dat_o(fp_m0_dat_o), .m0_ack_o(fp_m0_ack_o), .m0_err_o(fp_m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
    .m1_dat_o(fp_m1_dat_o), .m1_ack_o(fp_m1_ack_o), .m1_err_o(fp_m1_err_o),
    .s_adr_o(fp_s_adr_o), .s_dat_o(fp_s_dat_o), .s_we_o(fp_s_we_o), .s_sel_o(fp_s_sel_o),
    .s_cyc_o(fp_s_cyc_o), .s_stb_o(fp_s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 2 units later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    m0_adr_i = '0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    m1_adr_i = 32'h100; m1_dat_i = '0; m1_we_i = 1'b0; m1_sel_i = 4'hF;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    s_dat_i = 32'hAAAA_5555; s_ack_i = 1'b1; s_err_i = 1'b0;

    // Reset with a pending M1 request and a stray slave ack
    repeat (3) tick();
    #2;
    chk("rst_s_cyc", s_cyc_o, 0);
    chk("rst_s_stb", s_stb_o, 0);
    chk("rst_s_adr", s_adr_o, 0);
    chk("rst_s_sel", s_sel_o, 0);
    chk("rst_m1_ack", m1_ack_o, 0);
    chk("rst_m1_dat", m1_dat_o, 0);
    chk("rst_m0_dat", m0_dat_o, 0);
    rst = 1'b0; s_ack_i = 1'b0;

    // First M1 request granted on the next edge
    tick(); #2;
    chk("first_gnt_cyc", s_cyc_o, 1);
    chk("first_gnt_adr", s_adr_o, 32'h100);
    s_ack_i = 1'b1; s_dat_i = 32'h1111_2222; #2;
    chk("first_m1_ack", m1_ack_o, 1);
    chk("first_m1_dat", m1_dat_o, 32'h1111_2222);
    chk("first_m0_ack", m0_ack_o, 0);
    tick();
    s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    m0_adr_i = 32'h8; m0_cyc_i = 1'b1; m0_stb_i = 1'b1; #2;
    chk("dead_after_first", s_cyc_o, 0);

    // M0 alone reads 0x8, slave acks one cycle after the grant
    tick(); #2;
    chk("m0_gnt_adr", s_adr_o, 32'h8);
    chk("m0_gnt_sel", s_sel_o, 4'hF);
    chk("m0_gnt_we", s_we_o, 0);
    chk("m0_gnt_sdat", s_dat_o, 0);
    chk("m0_wait_ack", m0_ack_o, 0);
    tick();
    s_ack_i = 1'b1; s_dat_i = 32'h0010_1093; #2;
    chk("m0_rd_dat", m0_dat_o, 32'h0010_1093);
    chk("m0_rd_ack", m0_ack_o, 1);
    chk("m0_rd_m1_ack", m1_ack_o, 0);
    tick();
    s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0; #2;
    chk("m0_ack_pulse", m0_ack_o, 0);
    chk("m0_dead_cyc", s_cyc_o, 0);

    // Continuous contention: round robin D,I,D,I; fixed priority D every time
    m0_adr_i = 32'h200; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    m1_adr_i = 32'h300; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      s_ack_i = 1'b1; s_dat_i = 32'(i); #2;
      chk("rr_adr", s_adr_o, (i % 2 == 0) ? 32'h300 : 32'h200);
      chk("rr_m1_ack", m1_ack_o, (i % 2 == 0) ? 1 : 0);
      chk("rr_m0_ack", m0_ack_o, (i % 2 == 0) ? 0 : 1);
      chk("fp_adr", fp_s_adr_o, 32'h300);
      chk("fp_m1_ack", fp_m1_ack_o, 1);
      chk("fp_m0_ack", fp_m0_ack_o, 0);
      tick();
      s_ack_i = 1'b0; #2;
      chk("rr_dead_cyc", s_cyc_o, 0);
    end

    // M1 write against a simultaneous M0 read
    m1_adr_i = 32'h40; m1_dat_i = 32'hDEAD_BEEF; m1_sel_i = 4'b0011; m1_we_i = 1'b1;
    m0_adr_i = 32'h80;
    tick(); #2;
    chk("wr_adr", s_adr_o, 32'h40);
    chk("wr_dat", s_dat_o, 32'hDEAD_BEEF);
    chk("wr_we", s_we_o, 1);
    chk("wr_sel", s_sel_o, 4'b0011);
    chk("wr_stb", s_stb_o, 1);
    tick();
    s_ack_i = 1'b1; #2;
    chk("wr_m1_ack", m1_ack_o, 1);
    chk("wr_m0_ack", m0_ack_o, 0);
    tick();
    s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0; #2;
    chk("wr_dead_cyc", s_cyc_o, 0);
    tick();
    s_ack_i = 1'b1; s_dat_i = 32'h1234_5678; #2;
    chk("rd_after_wr_adr", s_adr_o, 32'h80);
    chk("rd_after_wr_we", s_we_o, 0);
    chk("rd_after_wr_sel", s_sel_o, 4'hF);
    chk("rd_after_wr_ack", m0_ack_o, 1);
    chk("rd_after_wr_dat", m0_dat_o, 32'h1234_5678);
    tick();
    s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    m1_adr_i = 32'h44; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;

    // Slave error during an M1 read
    tick();
    s_err_i = 1'b1; #2;
    chk("err_m1_err", m1_err_o, 1);
    chk("err_m0_err", m0_err_o, 0);
    chk("err_m1_ack", m1_ack_o, 0);
    tick();
    s_err_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0; #2;
    chk("err_pulse", m1_err_o, 0);
    chk("err_idle_cyc", s_cyc_o, 0);
    m0_adr_i = 32'h90; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;

    // Abort: M0 drops cyc while granted; a late slave ack is not forwarded
    tick(); #2;
    chk("abort_gnt_adr", s_adr_o, 32'h90);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; s_ack_i = 1'b1; #2;
    chk("abort_no_ack", m0_ack_o, 0);
    tick();
    s_ack_i = 1'b0; #2;
    chk("abort_idle_cyc", s_cyc_o, 0);
    m0_adr_i = 32'hC; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;

    // Slave never answers
    tick(); #2;
    chk("to_gnt_cyc", s_cyc_o, 1);
    chk("to_gnt_err", m0_err_o, 0);
`ifdef WB_ARB_TIMEOUT_EN
    repeat (15) tick();
    #2;
    chk("to_before_err", m0_err_o, 0);
    chk("to_before_cyc", s_cyc_o, 1);
    tick(); #2;
    chk("to_err_pulse", m0_err_o, 1);
    chk("to_cyc_drop", s_cyc_o, 0);
    chk("to_m1_err", m1_err_o, 0);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    tick(); #2;
    chk("to_err_end", m0_err_o, 0);
    chk("to_idle_cyc", s_cyc_o, 0);
`else
    repeat (100) tick();
    #2;
    chk("hold_cyc", s_cyc_o, 1);
    chk("hold_adr", s_adr_o, 32'hC);
    chk("hold_err", m0_err_o, 0);
    s_ack_i = 1'b1; s_dat_i = 32'hCAFE_0001; #2;
    chk("hold_late_ack", m0_ack_o, 1);
    chk("hold_late_dat", m0_dat_o, 32'hCAFE_0001);
    tick();
    s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0; #2;
    chk("hold_idle_cyc", s_cyc_o, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
